// File: rtl/lcd_frame_ctrl.sv
// lcd_frame_ctrl: 2xLINE_CHARS frame buffer replayed to the LCD driver one op at a time.
// Define LCD_FRAME_CTRL_CLEAR_EN to start every refresh with a CLEAR op.
module lcd_frame_ctrl #(
  parameter int LINE_CHARS = 16
) (
  input  logic       CCLK,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       busy,
  output logic       initlcd,
  output logic       resetlcd,
  output logic       clearlcd,
  output logic       homelcd,
  output logic       datalcd,
  output logic       addrlcd,
  output logic [7:0] lcddatin,
  input  logic       lcdreset,
  input  logic       lcdclear,
  input  logic       lcdhome,
  input  logic       lcddata,
  input  logic       lcdaddr
);

  localparam int NCH = 2 * LINE_CHARS;
  localparam logic [4:0] LAST0 = 5'(LINE_CHARS - 1);
  localparam logic [4:0] LAST1 = 5'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_PREP, S_ISSUE, S_GAP
  } state_t;

  typedef enum logic [1:0] {
    OP_RST, OP_CLR, OP_ADR, OP_DAT
  } op_t;

`ifdef LCD_FRAME_CTRL_CLEAR_EN
  localparam op_t REF_OP = OP_CLR;
`else
  localparam op_t REF_OP = OP_ADR;
`endif

  state_t     state;
  op_t        op;
  op_t        nop;
  logic [4:0] idx;
  logic [4:0] nidx;
  logic [7:0] ndat;
  logic       pwrup;
  logic       pend;
  logic       last;
  logic       done;
  logic       go;
  logic [7:0] fb [NCH];
  logic       unused;

  assign homelcd = 1'b0;
  assign unused  = lcdhome;

  // next op of the active list; after the last op, the refresh list restarts
  always_comb begin
    last = (op == OP_CLR && pwrup) ||
           (op == OP_DAT && idx == LAST1);
    nop  = op;
    nidx = idx;
    if (last) begin
      nop  = REF_OP;
      nidx = '0;
    end else begin
      unique case (op)
        OP_RST: nop = OP_CLR;
        OP_CLR: begin
          nop  = OP_ADR;
          nidx = '0;
        end
        OP_ADR: nop = OP_DAT;
        OP_DAT: begin
          nidx = idx + 5'd1;
          nop  = (idx == LAST0) ? OP_ADR : OP_DAT;
        end
      endcase
    end
    ndat = 8'h00;
    if (nop == OP_DAT)
      ndat = fb[nidx];
    else if (nop == OP_ADR)
      ndat = (nidx == '0) ? 8'h00 : 8'h40;
    go = pend || refresh;
  end

  always_comb begin
    done = 1'b0;
    unique case (1'b1)
      (op == OP_RST): done = lcdreset;
      (op == OP_CLR): done = lcdclear;
      (op == OP_ADR): done = lcdaddr;
      (op == OP_DAT): done = lcddata;
      default:        done = 1'b0;
    endcase
  end

  always_ff @(posedge CCLK or posedge reset) begin
    if (reset) begin
      state    <= S_PREP;
      op       <= OP_RST;
      idx      <= '0;
      pwrup    <= 1'b1;
      pend     <= 1'b0;
      busy     <= 1'b1;
      initlcd  <= 1'b1;
      resetlcd <= 1'b0;
      clearlcd <= 1'b0;
      datalcd  <= 1'b0;
      addrlcd  <= 1'b0;
      lcddatin <= 8'h00;
      for (int i = 0; i < NCH; i++)
        fb[i] <= 8'h20;
    end else begin
      if (wr_en && int'(wr_addr) < NCH)
        fb[wr_addr] <= wr_data;
      if (refresh && state != S_IDLE &&
          !(state == S_GAP && last))
        pend <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (refresh) begin
            state    <= S_PREP;
            op       <= nop;
            idx      <= nidx;
            pwrup    <= 1'b0;
            busy     <= 1'b1;
            initlcd  <= 1'b1;
            lcddatin <= ndat;
          end
        end
        S_PREP: begin
          state    <= S_ISSUE;
          initlcd  <= 1'b0;
          resetlcd <= (op == OP_RST);
          clearlcd <= (op == OP_CLR);
          addrlcd  <= (op == OP_ADR);
          datalcd  <= (op == OP_DAT);
        end
        S_ISSUE: begin
          if (done) begin
            state    <= S_GAP;
            resetlcd <= 1'b0;
            clearlcd <= 1'b0;
            addrlcd  <= 1'b0;
            datalcd  <= 1'b0;
          end
        end
        S_GAP: begin
          if (last && !go) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= S_PREP;
            op       <= nop;
            idx      <= nidx;
            initlcd  <= 1'b1;
            lcddatin <= ndat;
            if (last) begin
              pwrup <= 1'b0;
              pend  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// tb_lcd_frame_ctrl: directed vectors against a behavioural LCD driver model.
// Driver done flags set a programmable number of cycles after each strobe.
module tb_lcd_frame_ctrl;

`ifdef LCD_FRAME_CTRL_CLEAR_EN
  localparam int NPRE = 1;
`else
  localparam int NPRE = 0;
`endif
  localparam int NOPS = 34 + NPRE;

  logic       CCLK = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       refresh = 1'b0;
  logic       busy, initlcd;
  logic       resetlcd, clearlcd, homelcd, datalcd, addrlcd;
  logic [7:0] lcddatin;
  logic       lcdreset = 1'b0, lcdclear = 1'b0, lcdhome = 1'b0;
  logic       lcddata = 1'b0, lcdaddr = 1'b0;

  lcd_frame_ctrl #(.LINE_CHARS(16)) dut (
    .CCLK(CCLK), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .refresh(refresh), .busy(busy), .initlcd(initlcd),
    .resetlcd(resetlcd), .clearlcd(clearlcd), .homelcd(homelcd),
    .datalcd(datalcd), .addrlcd(addrlcd), .lcddatin(lcddatin),
    .lcdreset(lcdreset), .lcdclear(lcdclear), .lcdhome(lcdhome),
    .lcddata(lcddata), .lcdaddr(lcdaddr)
  );

  always #10 CCLK = ~CCLK;

  typedef struct packed {
    logic [2:0] k;
    logic [7:0] d;
  } op_rec_t;

  localparam logic [2:0] K_RST = 3'd1, K_CLR = 3'd2,
                         K_ADR = 3'd3, K_DAT = 3'd4;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         pos;
    logic [7:0] exp;
  } vec_t;

  op_rec_t log_q[$];
  op_rec_t exp_q[$];
  logic [7:0] exp_fb [32];
  vec_t vt [7];

  int checks = 0;
  int errors = 0;
  int viol = 0;
  int dly = 40;
  int cnt = 0;
  logic [3:0] strb;
  logic [3:0] prev = '0;

  assign strb = {resetlcd, clearlcd, addrlcd, datalcd};

  // driver model: flags clear on initlcd, set dly cycles into a strobe
  always @(posedge CCLK) begin
    if (initlcd) begin
      cnt <= 0;
      {lcdreset, lcdclear, lcdaddr, lcddata} <= '0;
    end else if (|strb && cnt < dly) begin
      cnt <= cnt + 1;
      if (cnt + 1 >= dly) begin
        if (resetlcd) lcdreset <= 1'b1;
        if (clearlcd) lcdclear <= 1'b1;
        if (addrlcd)  lcdaddr  <= 1'b1;
        if (datalcd)  lcddata  <= 1'b1;
      end
    end
  end

  always @(posedge CCLK) begin
    prev <= strb;
    if (resetlcd && !prev[3]) log_q.push_back({K_RST, lcddatin});
    if (clearlcd && !prev[2]) log_q.push_back({K_CLR, lcddatin});
    if (addrlcd  && !prev[1]) log_q.push_back({K_ADR, lcddatin});
    if (datalcd  && !prev[0]) log_q.push_back({K_DAT, lcddatin});
  end

  always @(negedge CCLK) begin
    if (!$onehot0(strb) || (initlcd && |strb) || homelcd)
      viol++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge CCLK); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", nm, maxc);
    end
  endtask

  task automatic wait_log(input string nm, input int n, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge CCLK); #1;
      if (log_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %0d ops logged, expected %0d", nm, log_q.size(), n);
    end
  endtask

  task automatic pulse_refresh();
    @(negedge CCLK) refresh = 1'b1;
    @(negedge CCLK) refresh = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d);
    @(negedge CCLK);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge CCLK) wr_en = 1'b0;
  endtask

  task automatic add_refresh();
    if (NPRE != 0) exp_q.push_back({K_CLR, 8'h00});
    exp_q.push_back({K_ADR, 8'h00});
    for (int i = 0; i < 16; i++) exp_q.push_back({K_DAT, exp_fb[i]});
    exp_q.push_back({K_ADR, 8'h40});
    for (int i = 16; i < 32; i++) exp_q.push_back({K_DAT, exp_fb[i]});
  endtask

  task automatic cmp_log(input string nm);
    int n;
    chk($sformatf("%s_count", nm), log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (exp_q[i].k == K_ADR || exp_q[i].k == K_DAT)
        chk($sformatf("%s_op%0d", nm, i), 32'(log_q[i]), 32'(exp_q[i]));
      else
        chk($sformatf("%s_op%0d", nm, i), 32'(log_q[i].k), 32'(exp_q[i].k));
    end
  endtask

  initial begin
    int hold;
    for (int i = 0; i < 32; i++) exp_fb[i] = 8'h20;
    vt[0] = '{5'd0,  8'h48, 1,  8'h48};
    vt[1] = '{5'd17, 8'h69, 19, 8'h69};
    vt[2] = '{5'd3,  8'h11, 4,  8'h33};
    vt[3] = '{5'd3,  8'h33, 4,  8'h33};
    vt[4] = '{5'd15, 8'h7A, 16, 8'h7A};
    vt[5] = '{5'd16, 8'h21, 18, 8'h21};
    vt[6] = '{5'd31, 8'h5A, 33, 8'h5A};

    // reset state
    repeat (3) @(posedge CCLK);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_initlcd", initlcd, 1);
    chk("rst_strobes", {strb, homelcd}, 0);
    chk("rst_lcddatin", lcddatin, 8'h00);

    // power-up list
    @(negedge CCLK) reset = 1'b0;
    wait_idle("pwrup_idle", 500);
    exp_q.delete();
    exp_q.push_back({K_RST, 8'h00});
    exp_q.push_back({K_CLR, 8'h00});
    cmp_log("pwrup");

    // refresh start latency and busy fall
    log_q.delete();
    exp_q.delete();
    @(negedge CCLK) refresh = 1'b1;
    @(posedge CCLK); #1;
    refresh = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_initlcd", initlcd, 1);
    chk("start_nostrobe", strb, 0);
    @(posedge CCLK); #1;
    chk("start_strobe", (NPRE != 0) ? clearlcd : addrlcd, 1);
    chk("start_initlcd_low", initlcd, 0);
    wait_log("blank_last", NOPS, 3000);
    for (int i = 0; i < 200; i++) begin
      if (strb == 0) break;
      @(posedge CCLK); #1;
    end
    chk("gap_busy", busy, 1);
    @(posedge CCLK); #1;
    chk("busy_fall", busy, 0);
    add_refresh();
    cmp_log("blank");

    // table-driven writes then refresh
    for (int i = 0; i < 7; i++) begin
      write(vt[i].a, vt[i].d);
      exp_fb[vt[i].a] = vt[i].d;
    end
    log_q.delete();
    exp_q.delete();
    pulse_refresh();
    wait_idle("frame_idle", 3000);
    add_refresh();
    cmp_log("frame");
    for (int i = 0; i < 7; i++)
      if (log_q.size() > NPRE + vt[i].pos)
        chk($sformatf("vec%0d", i), log_q[NPRE + vt[i].pos].d, vt[i].exp);

    // refresh requests merged while busy
    log_q.delete();
    exp_q.delete();
    pulse_refresh();
    repeat (100) @(negedge CCLK);
    pulse_refresh();
    repeat (400) @(negedge CCLK);
    pulse_refresh();
    repeat (400) @(negedge CCLK);
    pulse_refresh();
    wait_idle("merge_idle", 6000);
    add_refresh();
    add_refresh();
    cmp_log("merge");

    // write to the entry whose DATA op is in flight
    log_q.delete();
    exp_q.delete();
    pulse_refresh();
    wait_log("inflight_wait", NPRE + 7, 1000);
    write(5'd5, 8'h41);
    chk("inflight_strobe", datalcd, 1);
    chk("inflight_dat", lcddatin, 8'h20);
    wait_idle("inflight_idle", 3000);
    add_refresh();
    cmp_log("inflight");
    exp_fb[5] = 8'h41;
    log_q.delete();
    exp_q.delete();
    pulse_refresh();
    wait_idle("after_idle", 3000);
    add_refresh();
    cmp_log("after");

    // slow driver: strobe held until its done flag
    log_q.delete();
    exp_q.delete();
    dly = 10000;
    pulse_refresh();
    wait_log("slow_first", 1, 50);
    hold = 2;
    for (int i = 0; i < 20000; i++) begin
      @(posedge CCLK); #1;
      if (hold == 9000) chk("slow_noadvance", log_q.size(), 1);
      if (|strb) hold++;
      else break;
    end
    chk("slow_hold", hold, 10001);
    dly = 40;
    wait_idle("slow_idle", 3000);
    add_refresh();
    cmp_log("slow");

    // asynchronous reset mid-DATA
    log_q.delete();
    pulse_refresh();
    wait_log("midop_wait", NPRE + 2, 1000);
    @(posedge CCLK); #3;
    reset = 1'b1;
    #1;
    chk("midop_strobes", strb, 0);
    chk("midop_initlcd", initlcd, 1);
    chk("midop_busy", busy, 1);
    chk("midop_lcddatin", lcddatin, 8'h00);
    repeat (2) @(negedge CCLK);
    log_q.delete();
    exp_q.delete();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) exp_fb[i] = 8'h20;
    wait_idle("repwr_idle", 500);
    exp_q.push_back({K_RST, 8'h00});
    exp_q.push_back({K_CLR, 8'h00});
    cmp_log("repwr");
    log_q.delete();
    exp_q.delete();
    pulse_refresh();
    wait_idle("clean_idle", 3000);
    add_refresh();
    cmp_log("clean");

    chk("strobe_excl", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
